// File: rtl/fpmul.sv
// ---------------------------------------------------------------------------
// fpmul - sequential IEEE-754 binary32 multiplier.
//
// Computes InputA x InputB with a 24-step shift-and-add mantissa multiplier,
// then normalizes and rounds to nearest-even. Denormal operands are flushed
// to zero. Special operands finish one cycle after CHECK; normal operands
// take 27 cycles from the START edge to DONE.
//
// Handshake: START is sampled only while BUSY=0. The edge that samples START
// captures the operands and raises BUSY. DONE is a one-cycle pulse with
// BUSY=0, and AxB/EXCEPTION are valid in that cycle. A START in the DONE
// cycle is accepted, so operations can issue back to back. A START while
// BUSY=1 is dropped and is not queued.
//
// Ports:
//   CLOCK        in   1   rising-edge clock
//   RESET        in   1   synchronous active-high reset (wins over START)
//   START        in   1   operation request
//   InputA       in  32   operand A {sign, exp[7:0], frac[22:0]}
//   InputB       in  32   operand B
//   AxB          out 32   registered product, held until the next result
//   DONE         out  1   one-cycle result-valid pulse
//   BUSY         out  1   operation in progress
//   EXCEPTION    out  2   00 none, 01 underflow, 10 overflow, 11 invalid
//   o_dbg_state  out  3   current FSM state (debug)
// ---------------------------------------------------------------------------
module fpmul (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] InputA,
  input  logic [31:0] InputB,
  output logic [31:0] AxB,
  output logic        DONE,
  output logic        BUSY,
  output logic [1:0]  EXCEPTION,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MULT  = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4
  } state_t;

  state_t             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [23:0]        r_ma;
  logic [47:0]        r_p;
  logic signed [9:0]  r_e;
  logic [4:0]         r_cnt;
  logic               r_sign;
  logic [22:0]        r_m;
  logic               r_g;
  logic               r_s;

  // Operand classification (from captured operands)
  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic [22:0]        w_fa;
  logic [22:0]        w_fb;
  logic               w_sign;
  logic               w_nan_a;
  logic               w_nan_b;
  logic               w_inf_a;
  logic               w_inf_b;
  logic               w_zero_a;
  logic               w_zero_b;
  logic               w_invalid;
  logic               w_inf_res;
  logic               w_zero_res;
  logic signed [9:0]  w_exp_sum;

  // Multiplier step and rounding
  logic [24:0]        w_sum;
  logic [23:0]        w_m_inc;
  logic               w_round_up;
  logic [22:0]        w_m_fin;
  logic signed [9:0]  w_e_fin;

  assign w_ea   = r_a[30:23];
  assign w_eb   = r_b[30:23];
  assign w_fa   = r_a[22:0];
  assign w_fb   = r_b[22:0];
  assign w_sign = r_a[31] ^ r_b[31];

  assign w_nan_a  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_nan_b  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_inf_a  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_inf_b  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  // Exponent 0 covers both true zero and denormals (flushed to zero).
  assign w_zero_a = (w_ea == 8'h00);
  assign w_zero_b = (w_eb == 8'h00);

  assign w_invalid  = w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_inf_b & w_zero_a);
  assign w_inf_res  = w_inf_a | w_inf_b;
  assign w_zero_res = w_zero_a | w_zero_b;

  // Biased exponent sum, kept signed and wide enough for under/overflow.
  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  // One shift-and-add step: conditionally add mA into the upper half with the
  // carry kept as bit 24, so the right shift brings the carry back into P[47].
  assign w_sum = {1'b0, r_p[47:24]} + (r_p[0] ? {1'b0, r_ma} : 25'd0);

  // Round to nearest-even; a carry out of the 23-bit fraction means the
  // significand reached 2.0, which is 1.0 with the exponent bumped.
  assign w_round_up = r_g & (r_s | r_m[0]);
  assign w_m_inc    = {1'b0, r_m} + 24'd1;

  always_comb begin
    w_m_fin = r_m;
    w_e_fin = r_e;
    if (w_round_up) begin
      if (w_m_inc[23]) begin
        w_m_fin = 23'd0;
        w_e_fin = r_e + 10'sd1;
      end else begin
        w_m_fin = w_m_inc[22:0];
      end
    end
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_ma      <= 24'd0;
      r_p       <= 48'd0;
      r_e       <= 10'sd0;
      r_cnt     <= 5'd0;
      r_sign    <= 1'b0;
      r_m       <= 23'd0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      AxB       <= 32'd0;
      DONE      <= 1'b0;
      BUSY      <= 1'b0;
      EXCEPTION <= 2'b00;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a     <= InputA;
            r_b     <= InputB;
            BUSY    <= 1'b1;
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          r_sign <= w_sign;
          if (w_invalid) begin
            AxB       <= 32'h7FC0_0000;
            EXCEPTION <= 2'b11;
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_inf_res) begin
            AxB       <= {w_sign, 8'hFF, 23'd0};
            EXCEPTION <= 2'b00;
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_zero_res) begin
            AxB       <= {w_sign, 31'd0};
            EXCEPTION <= 2'b00;
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_ma    <= {1'b1, w_fa};
            r_p     <= {24'd0, 1'b1, w_fb};
            r_e     <= w_exp_sum;
            r_cnt   <= 5'd0;
            r_state <= S_MULT;
          end
        end

        S_MULT: begin
          r_p   <= {w_sum, r_p[23:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            r_state <= S_NORM;
          end
        end

        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4).
          if (r_p[47]) begin
            r_m <= r_p[46:24];
            r_g <= r_p[23];
            r_s <= |r_p[22:0];
            r_e <= r_e + 10'sd1;
          end else begin
            r_m <= r_p[45:23];
            r_g <= r_p[22];
            r_s <= |r_p[21:0];
          end
          r_state <= S_ROUND;
        end

        S_ROUND: begin
          if (w_e_fin >= 10'sd255) begin
            AxB       <= {r_sign, 8'hFF, 23'd0};
            EXCEPTION <= 2'b10;
          end else if (w_e_fin <= 10'sd0) begin
            AxB       <= {r_sign, 31'd0};
            EXCEPTION <= 2'b01;
          end else begin
            AxB       <= {r_sign, w_e_fin[7:0], w_m_fin};
            EXCEPTION <= 2'b00;
          end
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul.sv
// ---------------------------------------------------------------------------
// tb_fpmul - self-checking bench for fpmul.
//
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge. Each issued operation pushes its expected {EXCEPTION, AxB} onto
// exp_q; a monitor pops and compares whenever DONE is seen. Latency and BUSY
// duration are checked by the issuing sequence.
// ---------------------------------------------------------------------------
module tb_fpmul;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] axb;
  logic        done;
  logic        busy;
  logic [1:0]  exc;
  logic [2:0]  dbg_state;

  logic [33:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          done_cnt;

  fpmul dut (
    .CLOCK       (clk),
    .RESET       (rst),
    .START       (start),
    .InputA      (in_a),
    .InputB      (in_b),
    .AxB         (axb),
    .DONE        (done),
    .BUSY        (busy),
    .EXCEPTION   (exc),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
           (a[30:23] == 8'h00) || (b[30:23] == 8'h00);
  endfunction

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [47:0] p;
    logic [22:0] m;
    logic [23:0] m24;
    logic        g, st;
    int          e;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
        (ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00))
      return {2'b11, 32'h7FC0_0000};
    if (ea == 8'hFF || eb == 8'hFF) return {2'b00, s, 8'hFF, 23'd0};
    if (ea == 8'h00 || eb == 8'h00) return {2'b00, s, 31'd0};
    p = 48'({1'b1, fa}) * 48'({1'b1, fb});
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) begin
      m24 = {1'b0, m} + 24'd1;
      if (m24[23]) begin m = 23'd0; e = e + 1; end
      else m = m24[22:0];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && done) begin
      done_cnt++;
      check_eq("busy_in_done", 64'(busy), 64'd0);
      check_eq("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("axb", 64'(axb), 64'(e[31:0]));
        check_eq("exc", 64'(exc), 64'(e[33:32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on the falling edge after the START edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [33:0] exp);
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Waits for DONE, checking latency and BUSY duration. With disturb set,
  // a second START and operand changes are applied mid-operation.
  task automatic wait_done(input int exp_lat, input bit disturb);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 1;
    while (n < 100) begin
      if (disturb && n == 5) begin
        start = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4100_0000;
      end
      if (disturb && n == 6) start = 1'b0;
      if (disturb && n == 10) in_a = ~in_a;
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check_eq("latency", 64'(n), 64'(exp_lat));
    check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
  endtask

  task automatic run_model(input logic [31:0] a, input logic [31:0] b);
    start_op(a, b, model(a, b));
    wait_done(is_special(a, b) ? 1 : 27, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra, rb;
    int          dc;
    n_checks = 0; n_fail = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; in_a = 32'd0; in_b = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_axb", 64'(axb), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_exc", 64'(exc), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);

    // 2 x 3
    start_op(32'h4000_0000, 32'h4040_0000, {2'b00, 32'h40C0_0000});
    wait_done(27, 1'b0);

    // 1.5 x -1.5, then back-to-back RNE case issued in the DONE cycle
    start_op(32'h3FC0_0000, 32'hBFC0_0000, {2'b00, 32'hC010_0000});
    wait_done(27, 1'b0);
    start_op(32'h3F80_0001, 32'h3F80_0001, {2'b00, 32'h3F80_0002});
    wait_done(27, 1'b0);

    // overflow / underflow
    start_op(32'h7F00_0000, 32'h4000_0000, {2'b10, 32'h7F80_0000});
    wait_done(27, 1'b0);
    start_op(32'h0080_0000, 32'h3F00_0000, {2'b01, 32'h0000_0000});
    wait_done(27, 1'b0);

    // special operands
    start_op(32'h7F80_0000, 32'h0000_0000, {2'b11, 32'h7FC0_0000});
    wait_done(1, 1'b0);
    start_op(32'hFF80_0000, 32'h4000_0000, {2'b00, 32'hFF80_0000});
    wait_done(1, 1'b0);
    start_op(32'h8000_0000, 32'h3F80_0000, {2'b00, 32'h8000_0000});
    wait_done(1, 1'b0);
    start_op(32'h7FC0_1234, 32'h3F80_0000, {2'b11, 32'h7FC0_0000});
    wait_done(1, 1'b0);

    // START and InputA changes while busy are ignored
    start_op(32'h4000_0000, 32'h4040_0000, {2'b00, 32'h40C0_0000});
    wait_done(27, 1'b1);
    @(negedge clk);

    // random operands, a mix of moderate exponents and fully random words
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
        rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      run_model(ra, rb);
    end

    // leave a nonzero result/exception behind, then abort an operation
    start_op(32'h7F80_0000, 32'h0000_0000, {2'b11, 32'h7FC0_0000});
    wait_done(1, 1'b0);
    start_op(32'h4000_0000, 32'h4040_0000, {2'b00, 32'h40C0_0000});
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_eq("abort_axb", 64'(axb), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_exc", 64'(exc), 64'd0);
    dc = done_cnt;
    repeat (35) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt), 64'(dc));

    // RESET and START together: reset wins
    rst = 1'b1; start = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4000_0000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_eq("rst_start_busy", 64'(busy), 64'd0);
    check_eq("rst_start_state", 64'(dbg_state), 64'd0);

    // next operation completes normally
    start_op(32'h3FC0_0000, 32'hBFC0_0000, {2'b00, 32'hC010_0000});
    wait_done(27, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
